// File: rtl/poolb_ctrl_u3_if.sv
// Handshake/bus bundle between the pool sequencer and its buffers/datapath.
// master = sequencer side, slave = the environment that pulses start and consumes strobes.
interface poolb_ctrl_u3_if #(
    parameter int RD_ADDR_WIDTH = 13,
    parameter int WR_ADDR_WIDTH = 11
);
    logic                     start;
    logic                     rd_en;
    logic [RD_ADDR_WIDTH-1:0] rd_addr_A;
    logic [RD_ADDR_WIDTH-1:0] rd_addr_B;
    logic                     fifo_enable;
    logic                     pool_enable;
    logic                     wr_en;
    logic [WR_ADDR_WIDTH-1:0] wr_addr;
    logic                     busy;
    logic                     done;

    modport master (
        input  start,
        output rd_en, rd_addr_A, rd_addr_B, fifo_enable, pool_enable,
        output wr_en, wr_addr, busy, done
    );

    modport slave (
        output start,
        input  rd_en, rd_addr_A, rd_addr_B, fifo_enable, pool_enable,
        input  wr_en, wr_addr, busy, done
    );
endinterface

// File: rtl/poolb_ctrl_u3.sv
// Sequencer for the three-unit max-pool datapath: streams paired even/odd rows,
// applies buffer and pool latencies to the datapath strobes, and addresses the output buffer.
module poolb_ctrl_u3 #(
    parameter int IFM_SIZE      = 32,
    parameter int IFM_DEPTH     = 16,
    parameter int KERNAL_SIZE   = 2,
    parameter int POOL_LATENCY  = 1,
    localparam int NUM_PASSES   = (IFM_DEPTH + 2) / 3,
    parameter int RD_ADDR_WIDTH = $clog2(NUM_PASSES * IFM_SIZE * IFM_SIZE),
    parameter int WR_ADDR_WIDTH = $clog2(NUM_PASSES * (IFM_SIZE / 2) ** 2)
) (
    input logic             clk,
    input logic             reset,
    poolb_ctrl_u3_if.master bus
);

    localparam int COL_W  = (IFM_SIZE > 2) ? $clog2(IFM_SIZE) : 1;
    localparam int ROW_W  = (IFM_SIZE > 2) ? $clog2(IFM_SIZE / 2) : 1;
    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IFM_SIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IFM_SIZE / 2 - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);

    // End of a row pair: skip over the odd row that port B has already covered.
    localparam logic [RD_ADDR_WIDTH-1:0] ROW_STEP = RD_ADDR_WIDTH'(IFM_SIZE * (KERNAL_SIZE - 1) + 1);
    localparam logic [RD_ADDR_WIDTH-1:0] B_OFFSET = RD_ADDR_WIDTH'(IFM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t                   state_q, state_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]         orow_q, orow_d;
    logic [PASS_W-1:0]        pass_q, pass_d;
    logic [RD_ADDR_WIDTH-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [RD_ADDR_WIDTH-1:0] rd_addr_b_q, rd_addr_b_d;
    logic                     fifo_enable_q, fifo_enable_d;
    logic                     pool_enable_q, pool_enable_d;
    logic [POOL_LATENCY-1:0]  pipe_q, pipe_d;
    logic [WR_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                     wr_first_q, wr_first_d;
    logic                     done_q, done_d;

    logic rd_en;
    logic wr_en;
    logic last_rd;
    logic inflight;

    assign rd_en    = (state_q == S_READ);
    assign wr_en    = pipe_q[POOL_LATENCY-1];
    assign last_rd  = (col_q == COL_LAST) && (orow_q == ROW_LAST) && (pass_q == PASS_LAST);
    // Any pool strobe still travelling toward wr_en (top stage excluded).
    assign inflight = pool_enable_q | (|(pipe_q << 1));

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        orow_d        = orow_q;
        pass_d        = pass_q;
        rd_addr_a_d   = rd_addr_a_q;
        rd_addr_b_d   = rd_addr_b_q;
        wr_addr_d     = wr_addr_q;
        wr_first_d    = wr_first_q;
        done_d        = 1'b0;
        fifo_enable_d = rd_en;
        pool_enable_d = rd_en & col_q[0];
        pipe_d        = POOL_LATENCY'({pipe_q, pool_enable_q});

        // Address moves only just before a write so it holds the last written value.
        if (pipe_d[POOL_LATENCY-1]) begin
            wr_first_d = 1'b0;
            if (!wr_first_q) begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_READ;
                    col_d       = '0;
                    orow_d      = '0;
                    pass_d      = '0;
                    rd_addr_a_d = '0;
                    rd_addr_b_d = B_OFFSET;
                    wr_addr_d   = '0;
                    wr_first_d  = 1'b1;
                end
            end
            S_READ: begin
                if (last_rd) begin
                    state_d = S_DRAIN;
                end else begin
                    if (col_q == COL_LAST) begin
                        col_d       = '0;
                        rd_addr_a_d = rd_addr_a_q + ROW_STEP;
                        if (orow_q == ROW_LAST) begin
                            orow_d = '0;
                            pass_d = pass_q + 1'b1;
                        end else begin
                            orow_d = orow_q + 1'b1;
                        end
                    end else begin
                        col_d       = col_q + 1'b1;
                        rd_addr_a_d = rd_addr_a_q + 1'b1;
                    end
                    rd_addr_b_d = rd_addr_a_d + B_OFFSET;
                end
            end
            S_DRAIN: begin
                if (wr_en && !inflight) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            orow_q        <= '0;
            pass_q        <= '0;
            rd_addr_a_q   <= '0;
            rd_addr_b_q   <= '0;
            fifo_enable_q <= 1'b0;
            pool_enable_q <= 1'b0;
            pipe_q        <= '0;
            wr_addr_q     <= '0;
            wr_first_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            orow_q        <= orow_d;
            pass_q        <= pass_d;
            rd_addr_a_q   <= rd_addr_a_d;
            rd_addr_b_q   <= rd_addr_b_d;
            fifo_enable_q <= fifo_enable_d;
            pool_enable_q <= pool_enable_d;
            pipe_q        <= pipe_d;
            wr_addr_q     <= wr_addr_d;
            wr_first_q    <= wr_first_d;
            done_q        <= done_d;
        end
    end

    assign bus.rd_en       = rd_en;
    assign bus.rd_addr_A   = rd_addr_a_q;
    assign bus.rd_addr_B   = rd_addr_b_q;
    assign bus.fifo_enable = fifo_enable_q;
    assign bus.pool_enable = pool_enable_q;
    assign bus.wr_en       = wr_en;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;

endmodule

// File: tb/tb_poolb_ctrl_u3.sv
// Bench for poolb_ctrl_u3: three configurations (basic, two-pass, latency 3) run side by side
// against a cycle-indexed arithmetic reference derived from the read/write schedule.
module tb_poolb_ctrl_u3;

    localparam int S    = 4;
    localparam int NDUT = 3;
    localparam int RDW0 = 4;
    localparam int WRW0 = 2;
    localparam int RDW1 = 5;
    localparam int WRW1 = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    poolb_ctrl_u3_if #(.RD_ADDR_WIDTH(RDW0), .WR_ADDR_WIDTH(WRW0)) bus0 ();
    poolb_ctrl_u3_if #(.RD_ADDR_WIDTH(RDW1), .WR_ADDR_WIDTH(WRW1)) bus1 ();
    poolb_ctrl_u3_if #(.RD_ADDR_WIDTH(RDW0), .WR_ADDR_WIDTH(WRW0)) bus2 ();

    poolb_ctrl_u3 #(.IFM_SIZE(S), .IFM_DEPTH(3), .KERNAL_SIZE(2), .POOL_LATENCY(1),
                    .RD_ADDR_WIDTH(RDW0), .WR_ADDR_WIDTH(WRW0))
        dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
    poolb_ctrl_u3 #(.IFM_SIZE(S), .IFM_DEPTH(4), .KERNAL_SIZE(2), .POOL_LATENCY(1),
                    .RD_ADDR_WIDTH(RDW1), .WR_ADDR_WIDTH(WRW1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1.master));
    poolb_ctrl_u3 #(.IFM_SIZE(S), .IFM_DEPTH(3), .KERNAL_SIZE(2), .POOL_LATENCY(3),
                    .RD_ADDR_WIDTH(RDW0), .WR_ADDR_WIDTH(WRW0))
        dut2 (.clk(clk), .reset(reset), .bus(bus2.master));

    int lat    [NDUT] = '{1, 1, 3};
    int passes [NDUT] = '{1, 2, 1};
    bit active [NDUT];
    int base   [NDUT];
    int q;
    bit in_reset;
    int n_checks;
    int n_pass;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic int n_rd(input int d);
        return passes[d] * S * S / 2;
    endfunction

    function automatic int cur_t(input int d);
        return q - base[d] + 1;
    endfunction

    function automatic bit model_idle(input int d);
        if (in_reset) return 1'b0;
        if (!active[d]) return 1'b1;
        return cur_t(d) >= n_rd(d) + 2 + lat[d];
    endfunction

    task automatic drive_start(input int d, input bit v);
        case (d)
            0: bus0.start = v;
            1: bus1.start = v;
            default: bus2.start = v;
        endcase
        if (v && model_idle(d)) begin
            active[d] = 1'b1;
            base[d]   = q + 1;
        end
    endtask

    task automatic check_dut(input int d, input logic rd, input logic [31:0] a, input logic [31:0] b,
                             input logic fe, input logic pe, input logic we, input logic [31:0] wa,
                             input logic bsy, input logic dn);
        int t, n, l, k, per, p, r, orow, col, exp_a;
        bit run;
        n   = n_rd(d);
        l   = lat[d];
        t   = cur_t(d);
        run = !in_reset && active[d] && (t <= n + 2 + l);
        check_eq($sformatf("d%0d.t%0d.rd_en", d, t), 32'(rd), 32'(run && t >= 1 && t <= n));
        check_eq($sformatf("d%0d.t%0d.fifo_enable", d, t), 32'(fe), 32'(run && t >= 2 && t <= n + 1));
        check_eq($sformatf("d%0d.t%0d.pool_enable", d, t), 32'(pe),
                 32'(run && t >= 3 && t <= n + 1 && (t % 2) == 1));
        check_eq($sformatf("d%0d.t%0d.wr_en", d, t), 32'(we),
                 32'(run && t >= 3 + l && t <= n + 1 + l && ((t - l) % 2) == 1));
        check_eq($sformatf("d%0d.t%0d.busy", d, t), 32'(bsy), 32'(run && t <= n + 1 + l));
        check_eq($sformatf("d%0d.t%0d.done", d, t), 32'(dn), 32'(run && t == n + 2 + l));
        if (run && t >= 1 && t <= n) begin
            k     = t - 1;
            per   = S * S / 2;
            p     = k / per;
            r     = k % per;
            orow  = r / S;
            col   = r % S;
            exp_a = p * S * S + 2 * orow * S + col;
            check_eq($sformatf("d%0d.t%0d.rd_addr_A", d, t), a, 32'(exp_a));
            check_eq($sformatf("d%0d.t%0d.rd_addr_B", d, t), b, 32'(exp_a + S));
        end
        if (run && t >= 3 + l && t <= n + 1 + l && ((t - l) % 2) == 1)
            check_eq($sformatf("d%0d.t%0d.wr_addr", d, t), wa, 32'((t - l - 3) / 2));
        if (in_reset) begin
            check_eq($sformatf("d%0d.rst.rd_addr_A", d), a, 32'd0);
            check_eq($sformatf("d%0d.rst.rd_addr_B", d), b, 32'd0);
            check_eq($sformatf("d%0d.rst.wr_addr", d), wa, 32'd0);
        end
    endtask

    task automatic sample_all();
        check_dut(0, bus0.rd_en, 32'(bus0.rd_addr_A), 32'(bus0.rd_addr_B), bus0.fifo_enable,
                  bus0.pool_enable, bus0.wr_en, 32'(bus0.wr_addr), bus0.busy, bus0.done);
        check_dut(1, bus1.rd_en, 32'(bus1.rd_addr_A), 32'(bus1.rd_addr_B), bus1.fifo_enable,
                  bus1.pool_enable, bus1.wr_en, 32'(bus1.wr_addr), bus1.busy, bus1.done);
        check_dut(2, bus2.rd_en, 32'(bus2.rd_addr_A), 32'(bus2.rd_addr_B), bus2.fifo_enable,
                  bus2.pool_enable, bus2.wr_en, 32'(bus2.wr_addr), bus2.busy, bus2.done);
    endtask

    task automatic step();
        @(posedge clk);
        q++;
        @(negedge clk);
        sample_all();
    endtask

    task automatic clear_starts();
        for (int d = 0; d < NDUT; d++) drive_start(d, 1'b0);
    endtask

    // Called at a negedge: reset drops mid-cycle, outputs must clear without a clock edge.
    task automatic pulse_reset();
        clear_starts();
        reset    = 1'b0;
        in_reset = 1'b1;
        for (int d = 0; d < NDUT; d++) active[d] = 1'b0;
        #1;
        sample_all();
        step();
        step();
        reset    = 1'b1;
        in_reset = 1'b0;
    endtask

    initial begin
        q        = 0;
        n_checks = 0;
        n_pass   = 0;
        in_reset = 1'b1;
        reset    = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            active[d] = 1'b0;
            base[d]   = 0;
        end
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        bus2.start = 1'b0;

        repeat (3) step();
        reset    = 1'b1;
        in_reset = 1'b0;
        step();

        // All three configurations together, with an ignored second start in cycle 5.
        for (int d = 0; d < NDUT; d++) drive_start(d, 1'b1);
        step();
        for (int i = 0; i < 28; i++) begin
            for (int d = 0; d < NDUT; d++) drive_start(d, cur_t(d) == 5);
            step();
        end

        // Back-to-back maps: restart on each done cycle.
        for (int d = 0; d < NDUT; d++) drive_start(d, 1'b1);
        step();
        for (int i = 0; i < 60; i++) begin
            for (int d = 0; d < NDUT; d++) drive_start(d, active[d] && cur_t(d) == n_rd(d) + 2 + lat[d]);
            step();
        end
        clear_starts();
        repeat (25) step();

        // Abort mid-map at cycle 6, then a fresh full run.
        for (int d = 0; d < NDUT; d++) drive_start(d, 1'b1);
        step();
        clear_starts();
        for (int i = 0; i < 10 && cur_t(0) < 6; i++) step();
        pulse_reset();
        for (int d = 0; d < NDUT; d++) drive_start(d, 1'b1);
        step();
        clear_starts();
        repeat (25) step();

        // Random start traffic, including starts while busy and on done cycles.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_reset();
            for (int d = 0; d < NDUT; d++) drive_start(d, $urandom_range(0, 3) == 0);
            step();
        end
        clear_starts();
        repeat (30) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
